// File: rtl/ch77_restart_monitor_if.sv
// +---------------------------------------------------------------------------+
// | ch77_restart_monitor_if : AGC monitor time-pulse / channel / MDT bus        |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

interface ch77_restart_monitor_if;
   logic MT01, MT05, MT12;
   logic MWL01, MWL02, MWL03, MWL04, MWL05, MWL06;
   logic MRCH, MWCH;
   logic MDT01, MDT02, MDT03, MDT04, MDT05, MDT06, MDT07, MDT08;
   logic MDT09, MDT10, MDT11, MDT12, MDT13, MDT14, MDT15, MDT16;

   modport master (
      output MT01, MT05, MT12,
      output MWL01, MWL02, MWL03, MWL04, MWL05, MWL06,
      output MRCH, MWCH,
      input  MDT01, MDT02, MDT03, MDT04, MDT05, MDT06, MDT07, MDT08,
      input  MDT09, MDT10, MDT11, MDT12, MDT13, MDT14, MDT15, MDT16
   );

   modport slave (
      input  MT01, MT05, MT12,
      input  MWL01, MWL02, MWL03, MWL04, MWL05, MWL06,
      input  MRCH, MWCH,
      output MDT01, MDT02, MDT03, MDT04, MDT05, MDT06, MDT07, MDT08,
      output MDT09, MDT10, MDT11, MDT12, MDT13, MDT14, MDT15, MDT16
   );
endinterface

`default_nettype wire

// File: rtl/ch77_restart_monitor.sv
// +---------------------------------------------------------------------------+
// | ch77_restart_monitor : sticky AGC alarm register readable/clearable on     |
// | I/O channel 77. Option macro CH77_STOP_ON_ALARM_EN drives MSTP on alarm.    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module ch77_restart_monitor #(
   parameter logic [5:0] CHAN_ADDR   = 6'o77,
   parameter int         SYNC_STAGES = 2
) (
   input  logic SIM_CLK,
   input  logic SIM_RST_n,
   input  logic p4VSW,
   input  logic GND,
   ch77_restart_monitor_if.slave mon,
   input  logic MPAL_n,
   input  logic MTCAL_n,
   input  logic MRPTAL_n,
   input  logic MWATCH_n,
   input  logic MVFAIL_n,
   input  logic MCTRAL_n,
   input  logic MSCAFL_n,
   input  logic MSCDBL_n,
   output logic MNHSBF,
   output logic MNHNC,
   output logic MNHRPT,
   output logic MTCSAI,
   output logic MSTRT,
   output logic MSTP,
   output logic MSBSTP,
   output logic MRDCH,
   output logic MLDCH,
   output logic MONPAR,
   output logic MONWBK,
   output logic MLOAD,
   output logic MREAD,
   output logic NHALGA,
   output logic DOSCAL,
   output logic DBLTST,
   output logic MAMU
);

   // synchronizer stages hold the already-inverted (active-high) alarms
   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic [15:0]                 alm_q, alm_d;
   logic [5:0]                  addr_q, addr_d;
   logic                        hit_q, hit_d;
   logic                        cap_q, cap_d;
   logic                        mt05_q, mt05_d;

   logic [5:0]  w_wl;
   logic [15:0] w_alm_set;
   logic [15:0] w_mdt;
   logic        w_strobe;
   logic        w_clr;
   logic        w_unused;

   assign w_unused = GND;

   always_comb begin
      w_wl      = {mon.MWL06, mon.MWL05, mon.MWL04, mon.MWL03, mon.MWL02, mon.MWL01};
      w_strobe  = mon.MRCH | mon.MWCH;
      w_alm_set = {7'b0, sync_q[SYNC_STAGES-1][7:1], 1'b0, sync_q[SYNC_STAGES-1][0]};
      // edge-qualified so a multi-clock MT05 clears only once
      w_clr     = hit_q & mon.MWCH & mon.MT05 & ~mt05_q;

      sync_d    = sync_q;
      sync_d[0] = ~{MSCDBL_n, MSCAFL_n, MCTRAL_n, MVFAIL_n,
                    MWATCH_n, MRPTAL_n, MTCAL_n, MPAL_n};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      mt05_d = mon.MT05;
      cap_d  = mon.MT01 & w_strobe;
      addr_d = cap_d ? w_wl : addr_q;

      hit_d = hit_q;
      if (cap_q) begin
         hit_d = (addr_q == CHAN_ADDR);
      end
      if (mon.MT12 || !w_strobe) begin
         hit_d = 1'b0;
      end

      // set is OR-ed after the clear so a coincident alarm survives
      alm_d = (w_clr ? 16'h0000 : alm_q) | w_alm_set;

      if (!p4VSW) begin
         alm_d  = 16'h0000;
         addr_d = 6'd0;
         hit_d  = 1'b0;
         cap_d  = 1'b0;
      end

      w_mdt = (hit_q && mon.MRCH && !mon.MWCH && p4VSW) ? alm_q : 16'h0000;
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         sync_q <= '0;
         alm_q  <= 16'h0000;
         addr_q <= 6'd0;
         hit_q  <= 1'b0;
         cap_q  <= 1'b0;
         mt05_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         alm_q  <= alm_d;
         addr_q <= addr_d;
         hit_q  <= hit_d;
         cap_q  <= cap_d;
         mt05_q <= mt05_d;
      end
   end

   assign {mon.MDT16, mon.MDT15, mon.MDT14, mon.MDT13,
           mon.MDT12, mon.MDT11, mon.MDT10, mon.MDT09,
           mon.MDT08, mon.MDT07, mon.MDT06, mon.MDT05,
           mon.MDT04, mon.MDT03, mon.MDT02, mon.MDT01} = w_mdt;

`ifdef CH77_STOP_ON_ALARM_EN
   logic mstp_q, mstp_d;

   // ALM is sticky, so tracking "any bit set" holds MSTP until the clear
   always_comb begin
      mstp_d = p4VSW & (|alm_q);
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         mstp_q <= 1'b0;
      end else begin
         mstp_q <= mstp_d;
      end
   end

   assign MSTP = mstp_q;
`else
   assign MSTP = 1'b0;
`endif

   assign MNHSBF = 1'b0;
   assign MNHNC  = 1'b0;
   assign MNHRPT = 1'b0;
   assign MTCSAI = 1'b0;
   assign MSTRT  = 1'b0;
   assign MSBSTP = 1'b0;
   assign MRDCH  = 1'b0;
   assign MLDCH  = 1'b0;
   assign MONPAR = 1'b0;
   assign MONWBK = 1'b0;
   assign MLOAD  = 1'b0;
   assign MREAD  = 1'b0;
   assign NHALGA = 1'b0;
   assign DOSCAL = 1'b0;
   assign DBLTST = 1'b0;
   assign MAMU   = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_ch77_restart_monitor.sv
// +---------------------------------------------------------------------------+
// | tb_ch77_restart_monitor : directed bench for the channel 77 alarm monitor  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_ch77_restart_monitor;

   logic SIM_CLK = 1'b0;
   logic SIM_RST_n;
   logic p4VSW, GND;
   logic MPAL_n, MTCAL_n, MRPTAL_n, MWATCH_n, MVFAIL_n, MCTRAL_n, MSCAFL_n, MSCDBL_n;
   logic MNHSBF, MNHNC, MNHRPT, MTCSAI, MSTRT, MSTP, MSBSTP, MRDCH, MLDCH;
   logic MONPAR, MONWBK, MLOAD, MREAD, NHALGA, DOSCAL, DBLTST, MAMU;

   ch77_restart_monitor_if bus ();

   ch77_restart_monitor dut (
      .SIM_CLK  (SIM_CLK),
      .SIM_RST_n(SIM_RST_n),
      .p4VSW    (p4VSW),
      .GND      (GND),
      .mon      (bus.slave),
      .MPAL_n   (MPAL_n),
      .MTCAL_n  (MTCAL_n),
      .MRPTAL_n (MRPTAL_n),
      .MWATCH_n (MWATCH_n),
      .MVFAIL_n (MVFAIL_n),
      .MCTRAL_n (MCTRAL_n),
      .MSCAFL_n (MSCAFL_n),
      .MSCDBL_n (MSCDBL_n),
      .MNHSBF   (MNHSBF),
      .MNHNC    (MNHNC),
      .MNHRPT   (MNHRPT),
      .MTCSAI   (MTCSAI),
      .MSTRT    (MSTRT),
      .MSTP     (MSTP),
      .MSBSTP   (MSBSTP),
      .MRDCH    (MRDCH),
      .MLDCH    (MLDCH),
      .MONPAR   (MONPAR),
      .MONWBK   (MONWBK),
      .MLOAD    (MLOAD),
      .MREAD    (MREAD),
      .NHALGA   (NHALGA),
      .DOSCAL   (DOSCAL),
      .DBLTST   (DBLTST),
      .MAMU     (MAMU)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   logic [15:0] w_mdt;
   logic [15:0] w_ctrl;
   assign w_mdt  = {bus.MDT16, bus.MDT15, bus.MDT14, bus.MDT13,
                    bus.MDT12, bus.MDT11, bus.MDT10, bus.MDT09,
                    bus.MDT08, bus.MDT07, bus.MDT06, bus.MDT05,
                    bus.MDT04, bus.MDT03, bus.MDT02, bus.MDT01};
   assign w_ctrl = {MNHSBF, MNHNC, MNHRPT, MTCSAI, MSTRT, MSBSTP, MRDCH, MLDCH,
                    MONPAR, MONWBK, MLOAD, MREAD, NHALGA, DOSCAL, DBLTST, MAMU};

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] rd;
   logic        seen;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge SIM_CLK);
      #1;
   endtask

   task automatic set_wl(input logic [5:0] a);
      {bus.MWL06, bus.MWL05, bus.MWL04, bus.MWL03, bus.MWL02, bus.MWL01} = a;
   endtask

   // capture address with MT01, leave MRCH high so HIT stays up
   task automatic start_read(input logic [5:0] a);
      set_wl(a);
      bus.MT01 = 1'b1; bus.MRCH = 1'b1;
      tick();
      bus.MT01 = 1'b0;
      tick();
   endtask

   task automatic end_read();
      bus.MRCH = 1'b0;
      tick();
   endtask

   task automatic read_ch(input logic [5:0] a, output logic [15:0] d);
      start_read(a);
      d = w_mdt;
      end_read();
   endtask

   task automatic write_ch77();
      set_wl(6'o77);
      bus.MT01 = 1'b1; bus.MWCH = 1'b1;
      tick();
      bus.MT01 = 1'b0;
      tick();
      bus.MT05 = 1'b1;
      tick();
      bus.MT05 = 1'b0; bus.MWCH = 1'b0;
      tick();
   endtask

   initial begin
      SIM_RST_n = 1'b0; p4VSW = 1'b1; GND = 1'b0;
      bus.MT01 = 1'b0; bus.MT05 = 1'b0; bus.MT12 = 1'b0;
      bus.MRCH = 1'b0; bus.MWCH = 1'b0; set_wl(6'o0);
      {MPAL_n, MTCAL_n, MRPTAL_n, MWATCH_n, MVFAIL_n, MCTRAL_n, MSCAFL_n, MSCDBL_n} = 8'h00;
      repeat (3) tick();
      chk("rst_mdt",  w_mdt, 16'h0000);
      chk("rst_ctrl", w_ctrl, 16'h0000);
      chk("rst_mstp", {15'b0, MSTP}, 16'h0000);

      {MPAL_n, MTCAL_n, MRPTAL_n, MWATCH_n, MVFAIL_n, MCTRAL_n, MSCAFL_n, MSCDBL_n} = 8'hFF;
      tick();
      SIM_RST_n = 1'b1;
      repeat (3) tick();
      read_ch(6'o77, rd);
      chk("rst_read", rd, 16'h0000);

      // parity pulse -> ALM1
      MPAL_n = 1'b0; tick(); MPAL_n = 1'b1; repeat (3) tick();
      read_ch(6'o77, rd);
      chk("par_read1", rd, 16'h0001);
      read_ch(6'o77, rd);
      chk("par_read2", rd, 16'h0001);

      write_ch77();
      read_ch(6'o77, rd);
      chk("clr_read", rd, 16'h0000);

      // latency: held read shows ALM6 exactly 3 edges after input low
      start_read(6'o77);
      MVFAIL_n = 1'b0; tick(); MVFAIL_n = 1'b1; tick();
      chk("lat_edge2", w_mdt, 16'h0000);
      tick();
      chk("lat_edge3", w_mdt, 16'h0020);
      tick();
      chk("sticky", w_mdt, 16'h0020);
      bus.MT12 = 1'b1; tick(); bus.MT12 = 1'b0;
      chk("mt12_drop", w_mdt, 16'h0000);
      end_read();

      write_ch77();
      MTCAL_n = 1'b0; MWATCH_n = 1'b0; MSCDBL_n = 1'b0; tick();
      MTCAL_n = 1'b1; MWATCH_n = 1'b1; MSCDBL_n = 1'b1; repeat (3) tick();
      read_ch(6'o77, rd);
      chk("multi_map", rd, 16'o424);

      read_ch(6'o76, rd);
      chk("wrong_chan", rd, 16'h0000);
      read_ch(6'o77, rd);
      chk("wrong_keep", rd, 16'o424);

      // both strobes: treated as write, no MDT
      set_wl(6'o77);
      bus.MT01 = 1'b1; bus.MRCH = 1'b1; bus.MWCH = 1'b1; tick();
      bus.MT01 = 1'b0; tick();
      chk("both_mdt", w_mdt, 16'h0000);
      bus.MRCH = 1'b0; bus.MWCH = 1'b0; tick();
      read_ch(6'o77, rd);
      chk("both_keep", rd, 16'o424);

      // rupt-lock set lands on the same edge as the clear
      set_wl(6'o77);
      bus.MT01 = 1'b1; bus.MWCH = 1'b1; MRPTAL_n = 1'b0; tick();
      bus.MT01 = 1'b0; MRPTAL_n = 1'b1; tick();
      bus.MT05 = 1'b1; tick();
      bus.MT05 = 1'b0; bus.MWCH = 1'b0; tick();
      read_ch(6'o77, rd);
      chk("clr_set_race", rd, 16'h0008);

      // power-down clears ALM and blanks MDT
      start_read(6'o77);
      chk("pd_pre", w_mdt, 16'h0008);
      p4VSW = 1'b0; #1;
      chk("pd_mdt", w_mdt, 16'h0000);
      tick(); p4VSW = 1'b1;
      end_read();
      read_ch(6'o77, rd);
      chk("pd_read", rd, 16'h0000);

      // stop-on-alarm option
      seen = 1'b0;
      MVFAIL_n = 1'b0; tick(); MVFAIL_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (MSTP) seen = 1'b1;
      end
`ifdef CH77_STOP_ON_ALARM_EN
      chk("mstp_set", {15'b0, seen}, 16'h0001);
      write_ch77();
      chk("mstp_clr", {15'b0, MSTP}, 16'h0000);
`else
      chk("mstp_off", {15'b0, seen}, 16'h0000);
      write_ch77();
      chk("mstp_off2", {15'b0, MSTP}, 16'h0000);
`endif
      chk("ctrl_end", w_ctrl, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
